// File: rtl/sap1_display_scanner.sv
// SAP1 register viewer: shows one of NUM_SRC sources as hex nibbles plus a
// two-glyph label on a seven-segment bank. It supports manual select, timed
// auto-scroll, and a freeze mode that holds a snapshot and blinks its digits.
// Output glyph codes: 0-15 hex, 16 blank, 17 dash, 18+ letters.
module sap1_display_scanner #(
  parameter int DATA_W     = 8,
  parameter int NUM_SRC    = 7,
  parameter int NUM_DIGITS = 6,
  parameter int SCROLL_DIV = 50000000,
  parameter int BLINK_DIV  = 12500000,
  parameter int IDX_W      = $clog2(NUM_SRC)
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic [NUM_SRC*DATA_W-1:0]    srcData,
  input  logic [NUM_SRC*10-1:0]        srcLabel,
  input  logic [7:0]                   userSel,
  input  logic                         autoEn,
  input  logic                         nextBtn,
  input  logic                         freezeBtn,
  output logic [NUM_DIGITS*5-1:0]      hexData,
  output logic [IDX_W-1:0]             curIdx,
  output logic                         frozen,
  output logic                         scrollTick
);

  localparam int ND  = DATA_W / 4;
  localparam int SCW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam int BLW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [4:0] GLYPH_BLANK = 5'd16;
  localparam logic [4:0] GLYPH_DASH  = 5'd17;

  typedef enum logic [1:0] {
    ST_MANUAL = 2'd0,
    ST_AUTO   = 2'd1,
    ST_FROZEN = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          curIdx_q, curIdx_d;
  logic [SCW-1:0]            scrollCnt_q, scrollCnt_d;
  logic [BLW-1:0]            blinkCnt_q, blinkCnt_d;
  logic                      blinkPhase_q, blinkPhase_d;
  logic [DATA_W-1:0]         snapReg_q, snapReg_d;
  logic [NUM_DIGITS*5-1:0]   hexData_q, hexData_d;
  logic                      scrollTick_q, scrollTick_d;

  logic                      userValid;
  logic [IDX_W-1:0]          userIdx;
  logic [IDX_W-1:0]          wrapIdx;
  logic [DATA_W-1:0]         curData;
  logic [DATA_W-1:0]         dispVal;
  logic [9:0]                dispLabel;
  logic                      blankNib;

  // Decode the manual selection and the wrapped successor of the current index.
  always_comb begin
    userValid = (32'(userSel) < NUM_SRC);
    userIdx   = userSel[IDX_W-1:0];
    wrapIdx   = (curIdx_q == IDX_W'(NUM_SRC - 1)) ? '0 : curIdx_q + IDX_W'(1);
    curData   = srcData[curIdx_q*DATA_W +: DATA_W];
  end

  // Mode FSM next-state logic with the scroll and blink timers.
  always_comb begin
    state_d      = state_q;
    curIdx_d     = curIdx_q;
    scrollCnt_d  = scrollCnt_q;
    blinkCnt_d   = blinkCnt_q;
    blinkPhase_d = blinkPhase_q;
    snapReg_d    = snapReg_q;
    scrollTick_d = 1'b0;

    case (state_q)
      ST_MANUAL: begin
        if (freezeBtn) begin
          state_d      = ST_FROZEN;
          snapReg_d    = curData;
          blinkCnt_d   = '0;
          blinkPhase_d = 1'b0;
        end else if (autoEn) begin
          state_d     = ST_AUTO;
          curIdx_d    = userValid ? userIdx : '0;
          scrollCnt_d = '0;
        end
      end
      ST_AUTO: begin
        // A freeze request takes priority and drops a coincident nextBtn.
        if (freezeBtn) begin
          state_d      = ST_FROZEN;
          snapReg_d    = curData;
          blinkCnt_d   = '0;
          blinkPhase_d = 1'b0;
        end else if (!autoEn) begin
          state_d = ST_MANUAL;
        end else if (nextBtn || (scrollCnt_q == SCW'(SCROLL_DIV - 1))) begin
          // Terminal count and nextBtn together still give one step.
          curIdx_d     = wrapIdx;
          scrollCnt_d  = '0;
          scrollTick_d = 1'b1;
        end else begin
          scrollCnt_d = scrollCnt_q + SCW'(1);
        end
      end
      ST_FROZEN: begin
        if (blinkCnt_q == BLW'(BLINK_DIV - 1)) begin
          blinkCnt_d   = '0;
          blinkPhase_d = ~blinkPhase_q;
        end else begin
          blinkCnt_d = blinkCnt_q + BLW'(1);
        end
        if (freezeBtn) begin
          state_d     = autoEn ? ST_AUTO : ST_MANUAL;
          scrollCnt_d = '0;
        end
      end
      default: begin
        state_d = ST_MANUAL;
      end
    endcase

    // In manual mode the index tracks any valid selection every cycle.
    if ((state_d == ST_MANUAL) && userValid) begin
      curIdx_d = userIdx;
    end
  end

  // Build the glyph image from the post-edge mode so the display has one cycle latency.
  always_comb begin
    hexData_d = {NUM_DIGITS{GLYPH_BLANK}};
    dispVal   = (state_d == ST_FROZEN) ? snapReg_d : srcData[curIdx_d*DATA_W +: DATA_W];
    dispLabel = srcLabel[curIdx_d*10 +: 10];
    blankNib  = (state_d == ST_FROZEN) && blinkPhase_d;

    if ((state_d == ST_MANUAL) && !userValid) begin
      hexData_d = {NUM_DIGITS{GLYPH_DASH}};
    end else begin
      for (int k = 0; k < ND; k++) begin
        hexData_d[k*5 +: 5] = blankNib ? GLYPH_BLANK : {1'b0, dispVal[k*4 +: 4]};
      end
      hexData_d[ND*5 +: 5]     = GLYPH_DASH;
      hexData_d[(ND+1)*5 +: 5] = dispLabel[4:0];
      hexData_d[(ND+2)*5 +: 5] = dispLabel[9:5];
    end
  end

  // State and output registers; reset drops any freeze in progress.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= ST_MANUAL;
      curIdx_q     <= '0;
      scrollCnt_q  <= '0;
      blinkCnt_q   <= '0;
      blinkPhase_q <= 1'b0;
      snapReg_q    <= '0;
      hexData_q    <= {NUM_DIGITS{GLYPH_DASH}};
      scrollTick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      curIdx_q     <= curIdx_d;
      scrollCnt_q  <= scrollCnt_d;
      blinkCnt_q   <= blinkCnt_d;
      blinkPhase_q <= blinkPhase_d;
      snapReg_q    <= snapReg_d;
      hexData_q    <= hexData_d;
      scrollTick_q <= scrollTick_d;
    end
  end

  assign hexData    = hexData_q;
  assign curIdx     = curIdx_q;
  assign frozen     = (state_q == ST_FROZEN);
  assign scrollTick = scrollTick_q;

endmodule

// File: tb/tb_sap1_display_scanner.sv
// Scoreboard bench for sap1_display_scanner: a driver predicts every cycle's
// outputs from a behavioural model and queues them; a monitor pops and compares.
module tb_sap1_display_scanner;

  localparam int DATA_W     = 8;
  localparam int NUM_SRC    = 7;
  localparam int NUM_DIGITS = 6;
  localparam int SCROLL_DIV = 4;
  localparam int BLINK_DIV  = 2;
  localparam int IDX_W      = 3;

  localparam int MAN = 0;
  localparam int AUT = 1;
  localparam int FRZ = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                         resetN;
  logic [NUM_SRC*DATA_W-1:0]    srcData;
  logic [NUM_SRC*10-1:0]        srcLabel;
  logic [7:0]                   userSel;
  logic                         autoEn;
  logic                         nextBtn;
  logic                         freezeBtn;
  logic [NUM_DIGITS*5-1:0]      hexData;
  logic [IDX_W-1:0]             curIdx;
  logic                         frozen;
  logic                         scrollTick;

  logic [7:0] src   [NUM_SRC];
  logic [4:0] lblHi [NUM_SRC];
  logic [4:0] lblLo [NUM_SRC];

  always_comb begin
    srcData  = '0;
    srcLabel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      srcData[i*8 +: 8]   = src[i];
      srcLabel[i*10 +: 10] = {lblHi[i], lblLo[i]};
    end
  end

  sap1_display_scanner #(
    .DATA_W(DATA_W), .NUM_SRC(NUM_SRC), .NUM_DIGITS(NUM_DIGITS),
    .SCROLL_DIV(SCROLL_DIV), .BLINK_DIV(BLINK_DIV), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .resetN(resetN), .srcData(srcData), .srcLabel(srcLabel),
    .userSel(userSel), .autoEn(autoEn), .nextBtn(nextBtn), .freezeBtn(freezeBtn),
    .hexData(hexData), .curIdx(curIdx), .frozen(frozen), .scrollTick(scrollTick)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [NUM_DIGITS*5-1:0] hex;
    logic [IDX_W-1:0]        idx;
    logic                    frz;
    logic                    tick;
  } exp_t;

  exp_t expQ [$];
  exp_t monE;

  // Reference model: mode, index, cycles since last advance, cycles since freeze.
  int         m_mode;
  int         m_idx;
  int         m_sinceAdv;
  int         m_sinceFrz;
  logic [7:0] m_snap;
  bit         m_tick;

  task automatic model_reset();
    m_mode = MAN; m_idx = 0; m_sinceAdv = 0; m_sinceFrz = 0; m_snap = 8'h00; m_tick = 1'b0;
  endtask

  function automatic logic [NUM_DIGITS*5-1:0] render(bit invalid, logic [7:0] val, bit blank, int idx);
    int d [NUM_DIGITS];
    logic [NUM_DIGITS*5-1:0] r;
    if (invalid) begin
      for (int k = 0; k < NUM_DIGITS; k++) d[k] = 17;
    end else begin
      d[0] = blank ? 16 : int'(val) % 16;
      d[1] = blank ? 16 : int'(val) / 16;
      d[2] = 17;
      d[3] = int'(lblLo[idx]);
      d[4] = int'(lblHi[idx]);
      d[5] = 16;
    end
    r = '0;
    for (int k = 0; k < NUM_DIGITS; k++) r[k*5 +: 5] = 5'(d[k]);
    return r;
  endfunction

  task automatic model_step(output exp_t e);
    bit valid;
    bit blank;
    logic [7:0] val;
    valid  = (int'(userSel) < NUM_SRC);
    m_tick = 1'b0;
    if (m_mode == FRZ) begin
      m_sinceFrz++;
      if (freezeBtn) begin
        m_mode = autoEn ? AUT : MAN;
        m_sinceAdv = 0;
      end
    end else if (freezeBtn) begin
      m_snap = src[m_idx];
      m_mode = FRZ;
      m_sinceFrz = 0;
    end else if (m_mode == MAN) begin
      if (autoEn) begin
        m_mode = AUT;
        m_idx = valid ? int'(userSel) : 0;
        m_sinceAdv = 0;
      end
    end else begin
      if (!autoEn) begin
        m_mode = MAN;
      end else if (nextBtn || m_sinceAdv == SCROLL_DIV - 1) begin
        m_idx = (m_idx + 1) % NUM_SRC;
        m_sinceAdv = 0;
        m_tick = 1'b1;
      end else begin
        m_sinceAdv++;
      end
    end
    if (m_mode == MAN && valid) m_idx = int'(userSel);

    val   = (m_mode == FRZ) ? m_snap : src[m_idx];
    blank = (m_mode == FRZ) && ((m_sinceFrz / BLINK_DIV) % 2 == 1);
    e.hex  = render((m_mode == MAN) && !valid, val, blank, m_idx);
    e.idx  = IDX_W'(m_idx);
    e.frz  = (m_mode == FRZ);
    e.tick = m_tick;
  endtask

  // Called at a falling edge with inputs already applied; returns at the next falling edge.
  task automatic step();
    exp_t e;
    model_step(e);
    expQ.push_back(e);
    @(negedge clk);
  endtask

  task automatic async_reset(input string tag);
    #2 resetN = 1'b0;
    #1;
    chk({tag, "_hex"},   32'(hexData),    32'({NUM_DIGITS{5'd17}}));
    chk({tag, "_idx"},   32'(curIdx),     32'd0);
    chk({tag, "_frz"},   32'(frozen),     32'd0);
    chk({tag, "_tick"},  32'(scrollTick), 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    resetN = 1'b1;
  endtask

  // Monitor: every cycle the DUT presents a new registered output set.
  always @(posedge clk) begin
    #1;
    if (expQ.size() > 0) begin
      monE = expQ.pop_front();
      chk("hexData",    32'(hexData),    32'(monE.hex));
      chk("curIdx",     32'(curIdx),     32'(monE.idx));
      chk("frozen",     32'(frozen),     32'(monE.frz));
      chk("scrollTick", 32'(scrollTick), 32'(monE.tick));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int prevIdx;
    resetN = 1'b0; userSel = 8'd0; autoEn = 1'b0; nextBtn = 1'b0; freezeBtn = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src[i]   = 8'($urandom);
      lblHi[i] = 5'(18 + $urandom_range(0, 13));
      lblLo[i] = 5'(18 + $urandom_range(0, 13));
    end
    src[0] = 8'h3A; lblHi[0] = 5'd18; lblLo[0] = 5'd19;
    src[2] = 8'h5C;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    chk("rst_hex",  32'(hexData),    32'({NUM_DIGITS{5'd17}}));
    chk("rst_idx",  32'(curIdx),     32'd0);
    chk("rst_frz",  32'(frozen),     32'd0);
    chk("rst_tick", 32'(scrollTick), 32'd0);
    @(negedge clk);
    resetN = 1'b1;

    // Manual view of PC.
    step();
    chk("t1_hex", 32'(hexData), 32'({5'd16, 5'd18, 5'd19, 5'd17, 5'd3, 5'd10}));
    chk("t1_idx", 32'(curIdx), 32'd0);

    // Out-of-range selection.
    userSel = 8'd9;
    step();
    chk("t2_hex", 32'(hexData), 32'({NUM_DIGITS{5'd17}}));
    chk("t2_idx", 32'(curIdx), 32'd0);
    step();

    // Auto-scroll from 5, wrap, and nextBtn on the terminal cycle.
    autoEn = 1'b1; userSel = 8'd5;
    step();
    chk("t3_idx5", 32'(curIdx), 32'd5);
    userSel = 8'd1;
    repeat (3) step();
    chk("t3_hold", 32'(curIdx), 32'd5);
    step();
    chk("t3_idx6", 32'(curIdx), 32'd6);
    chk("t3_tick", 32'(scrollTick), 32'd1);
    repeat (3) step();
    nextBtn = 1'b1;
    step();
    nextBtn = 1'b0;
    chk("t3_wrap", 32'(curIdx), 32'd0);
    repeat (3) step();
    chk("t3_cleared", 32'(curIdx), 32'd0);

    // Freeze while showing MDR.
    for (int n = 0; n < 40 && m_idx != 2; n++) step();
    chk("t4_at2", 32'(curIdx), 32'd2);
    freezeBtn = 1'b1;
    step();
    freezeBtn = 1'b0;
    src[2] = 8'h11;
    chk("t4_snap", 32'(hexData[9:0]), 32'({5'd5, 5'd12}));
    step();
    step();
    chk("t4_blink", 32'(hexData[9:0]), 32'({5'd16, 5'd16}));
    for (int n = 0; n < 18; n++) begin
      userSel = 8'($urandom_range(0, 9));
      nextBtn = ($urandom_range(0, 2) == 0);
      step();
    end
    nextBtn = 1'b0;
    chk("t4_idx", 32'(curIdx), 32'd2);

    // Leave freeze, then freeze and next together, then resume.
    freezeBtn = 1'b1;
    step();
    freezeBtn = 1'b0;
    chk("t5_live", 32'(hexData[9:0]), 32'({5'd1, 5'd1}));
    step();
    prevIdx = m_idx;
    freezeBtn = 1'b1; nextBtn = 1'b1;
    step();
    freezeBtn = 1'b0; nextBtn = 1'b0;
    chk("t5_frz", 32'(frozen), 32'd1);
    chk("t5_idx", 32'(curIdx), 32'(prevIdx));
    repeat (2) step();
    freezeBtn = 1'b1;
    step();
    freezeBtn = 1'b0;
    chk("t5_resume", 32'(frozen), 32'd0);
    repeat (5) step();

    // Asynchronous reset in the middle of a freeze.
    freezeBtn = 1'b1;
    step();
    freezeBtn = 1'b0;
    repeat (3) step();
    async_reset("t6");
    autoEn = 1'b0; userSel = 8'd3;
    step();

    // Randomised traffic.
    for (int it = 0; it < 600; it++) begin
      if ($urandom_range(0, 19) == 0) autoEn = ~autoEn;
      userSel   = 8'($urandom_range(0, 9));
      nextBtn   = ($urandom_range(0, 5) == 0);
      freezeBtn = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 3) == 0) src[$urandom_range(0, NUM_SRC - 1)] = 8'($urandom);
      if (it == 300) async_reset("rnd_rst");
      step();
    end
    nextBtn = 1'b0; freezeBtn = 1'b0;
    step();
    @(posedge clk);
    #2;
    chk("queue_drained", 32'(expQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
